// File: rtl/reg_file_param.sv
// Parameterized register file with two combinational read ports, write-through
// bypass, and a one-entry-per-cycle bulk clear sequencer.
module reg_file_param #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        WEN,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] WADR,
  input  logic [WIDTH-1:0]                            DIN,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] RADR1,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] RADR2,
  output logic [WIDTH-1:0]                            OUT1,
  output logic [WIDTH-1:0]                            OUT2,
  input  logic                                        CLR,
  output logic                                        BUSY
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH itself is representable for range checks.
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];

  logic wr_en, rd1_ok, rd2_ok;

  assign wr_en  = WEN && !busy_q && ({1'b0, WADR} < DEPTH_W);
  assign rd1_ok = rst_n && ({1'b0, RADR1} < DEPTH_W);
  assign rd2_ok = rst_n && ({1'b0, RADR2} < DEPTH_W);

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    mem_d   = mem_q;
    unique case (state_q)
      IDLE: begin
        if (wr_en) mem_d[WADR] = DIN;
        if (CLR) begin
          state_d = SWEEP;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SWEEP: begin
        mem_d[cnt_q] = '0;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking stays in always_comb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // NOTE: the storage must clear asynchronously, so it is built from resettable flops, not a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign OUT1 = !rd1_ok ? '0 : (wr_en && RADR1 == WADR) ? DIN : mem_q[RADR1];
  assign OUT2 = !rd2_ok ? '0 : (wr_en && RADR2 == WADR) ? DIN : mem_q[RADR2];
  assign BUSY = busy_q;

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001: Parameter WIDTH, default 16, data width of each entry in bits (>=1).
REQ-002: Parameter DEPTH, default 16, number of entries (>=2; need not be a power of two).
REQ-003: Derived localparam AW = ceil(log2(DEPTH)), address width.
REQ-004: Port clk, input, 1, single clock; all state updates on rising edge.
REQ-005: Port rst_n, input, 1, asynchronous active-low reset.
REQ-006: Port WEN, input, 1, write enable.
REQ-007: Port WADR, input, AW, write address.
REQ-008: Port DIN, input, WIDTH, write data.
REQ-009: Port RADR1, input, AW, read address, port 1.
REQ-010: Port RADR2, input, AW, read address, port 2.
REQ-011: Port OUT1, output, WIDTH, read data, port 1 (combinational).
REQ-012: Port OUT2, output, WIDTH, read data, port 2 (combinational).
REQ-013: Port CLR, input, 1, request bulk clear of all entries.
REQ-014: Port BUSY, output, 1, high while a bulk clear is in progress.

Function
REQ-015: Storage SHALL be DEPTH entries of WIDTH bits.
REQ-016: Write SHALL occur at rising clk when WEN=1, BUSY=0, and WADR<DEPTH: entry[WADR] <= DIN.
REQ-017: WEN SHALL be ignored while BUSY=1; write with WADR>=DEPTH SHALL be discarded.
REQ-018: OUTn SHALL equal entry[RADRn] combinationally, zero latency.
REQ-019: Write-through bypass: when WEN=1, BUSY=0, WADR<DEPTH and RADRn==WADR, OUTn SHALL equal DIN in the same cycle.
REQ-020: RADRn>=DEPTH SHALL read as all zeros, with no bypass.
REQ-021: Both read ports SHALL be independent; RADR1==RADR2 SHALL return identical data.
REQ-022: Clear FSM SHALL have two states: IDLE and SWEEP; sweep counter CNT is AW bits.
REQ-023: IDLE: CLR=1 at rising clk -> SWEEP, CNT <= 0; else stay IDLE.
REQ-024: SWEEP: each rising clk writes 0 to entry[CNT] and increments CNT.
REQ-025: SWEEP with CNT==DEPTH-1: entry cleared, -> IDLE, CNT <= 0; bulk clear SHALL take exactly DEPTH cycles.
REQ-026: BUSY SHALL be 1 exactly when state==SWEEP (registered, no combinational path from CLR).
REQ-027: CLR while in SWEEP SHALL be ignored (no restart, no extension).
REQ-028: CLR and a valid write in the same IDLE cycle: write SHALL commit, then the sweep clears it.
REQ-029: Reads during SWEEP SHALL return current contents: zero for entries already swept, old data otherwise.
REQ-030: Back-to-back: CLR held high on the cycle SWEEP returns to IDLE SHALL start a new sweep on the next edge.

Reset
REQ-031: rst_n=0 SHALL asynchronously force all entries to 0, state to IDLE, CNT to 0, BUSY to 0.
REQ-032: Reset asserted mid-sweep SHALL abort the sweep; after release the block SHALL be IDLE with all entries zero.
REQ-033: Writes and CLR SHALL be ignored while rst_n=0; OUTn SHALL read 0 (no bypass) while rst_n=0.
REQ-034: First write SHALL be accepted on the first rising clk after rst_n deasserts.

Verification
REQ-035: Reset, write 0xA5A5 to addr 3, then 0x1234 to addr 15 -> RADR1=3 gives 0xA5A5, RADR2=15 gives 0x1234 on the next cycle.
REQ-036: WEN=1, WADR=7, DIN=0xBEEF, RADR1=7 in same cycle -> OUT1=0xBEEF before the edge (bypass), and after the edge with WEN=0.
REQ-037: Fill all 16 entries with index value, pulse CLR -> BUSY high exactly 16 cycles; mid-sweep, addr 2 reads 0 and addr 10 reads 10; after completion all read 0.
REQ-038: WEN=1 addr 5 during BUSY -> entry 5 unchanged, no bypass; CLR re-pulsed mid-sweep -> BUSY still drops after 16 total cycles.
REQ-039: Assert rst_n=0 mid-sweep at CNT=6, with no clock edge -> BUSY falls immediately, all reads 0.
REQ-040: DEPTH=12, WIDTH=8 build -> write to addr 13 discarded, RADR1=13 reads 0x00, sweep lasts 12 cycles.
